// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared widths and controller state type for the CNN datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

   localparam int PIX_W    = 16;
   localparam int LB_PIX_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } ctrl_state_t;

   // Counter width that stays legal for a degenerate 1-entry range.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// ============================================================================
// Module      : raster_counter
// Description : Raster col/row position counter with clear, increment and
//               last-pixel flag; wraps to (0,0) after the last pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module raster_counter
   import cnn_pkg::*;
#(
   parameter int COLS = 4,
   parameter int ROWS = 4,
   parameter int CW   = cnt_w(COLS),
   parameter int RW   = cnt_w(ROWS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          inc_i,
   output logic [CW-1:0] col_o,
   output logic [RW-1:0] row_o,
   output logic          last_o
);

   localparam logic [CW-1:0] C_COL_LAST = CW'(COLS - 1);
   localparam logic [RW-1:0] C_ROW_LAST = RW'(ROWS - 1);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clr_i) begin
         col_d = '0;
         row_d = '0;
      end else if (inc_i) begin
         if (col_q == C_COL_LAST) begin
            col_d = '0;
            row_d = (row_q == C_ROW_LAST) ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign col_o  = col_q;
   assign row_o  = row_q;
   assign last_o = (col_q == C_COL_LAST) && (row_q == C_ROW_LAST);

endmodule
`default_nettype wire

// File: rtl/conv_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_ctrl
// Description : Line-buffer / KxK window sequencer for one convolution layer.
//               Define CONV_WIN_STRIDE2_EN to flag only stride-2 windows.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_ctrl
   import cnn_pkg::*;
#(
   parameter int IMG_W = 4,
   parameter int IMG_H = 4,
   parameter int K     = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     pix_valid,
   input  logic [PIX_W-1:0]         pix_in,
   output logic                     pix_ready,
   input  logic                     out_ready,
   output logic                     lb_en,
   output logic [PIX_W-1:0]         lb_pixel,
   output logic                     win_valid,
   output logic [$clog2(IMG_H)-1:0] win_row,
   output logic [$clog2(IMG_W)-1:0] win_col,
   output logic                     busy,
   output logic                     done
);

   localparam int RW = $clog2(IMG_H);
   localparam int CW = $clog2(IMG_W);

   localparam logic [RW-1:0] C_K_ROW = RW'(K - 1);
   localparam logic [CW-1:0] C_K_COL = CW'(K - 1);

   ctrl_state_t   state_q, state_d;
   logic          win_valid_q, win_valid_d;
   logic [RW-1:0] win_row_q, win_row_d;
   logic [CW-1:0] win_col_q, win_col_d;

   logic          w_accept;
   logic          w_clr;
   logic          w_last;
   logic          w_in_window;
   logic          w_stride_ok;
   logic [CW-1:0] w_col;
   logic [RW-1:0] w_row;

   assign pix_ready = (state_q == STREAM) && out_ready;
   assign w_accept  = pix_valid && pix_ready;
   assign lb_en     = w_accept;
   assign lb_pixel  = pix_in;
   assign w_clr     = (state_q == IDLE) && start;

   raster_counter #(
      .COLS (IMG_W),
      .ROWS (IMG_H),
      .CW   (CW),
      .RW   (RW)
   ) u_raster_counter (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (w_clr),
      .inc_i  (w_accept),
      .col_o  (w_col),
      .row_o  (w_row),
      .last_o (w_last)
   );

   assign w_in_window = (w_row >= C_K_ROW) && (w_col >= C_K_COL);

`ifdef CONV_WIN_STRIDE2_EN
   // Even offset from the first window position <=> matching LSB.
   assign w_stride_ok = (w_row[0] == C_K_ROW[0]) && (w_col[0] == C_K_COL[0]);
`else
   assign w_stride_ok = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = STREAM;
         STREAM:  if (w_accept && w_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      win_valid_d = w_accept && w_in_window && w_stride_ok;
      win_row_d   = win_row_q;
      win_col_d   = win_col_q;
      if (win_valid_d) begin
         win_row_d = w_row;
         win_col_d = w_col;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         win_valid_q <= 1'b0;
         win_row_q   <= '0;
         win_col_q   <= '0;
      end else begin
         state_q     <= state_d;
         win_valid_q <= win_valid_d;
         win_row_q   <= win_row_d;
         win_col_q   <= win_col_d;
      end
   end

   assign win_valid = win_valid_q;
   assign win_row   = win_row_q;
   assign win_col   = win_col_q;
   assign busy      = (state_q == STREAM);
   assign done      = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_conv_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_window_ctrl
// Description : Self-checking bench for conv_window_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_ctrl;
   import cnn_pkg::*;

`ifdef CONV_WIN_STRIDE2_EN
   localparam int IMG_W = 5;
   localparam int IMG_H = 5;
   localparam int S     = 2;
`else
   localparam int IMG_W = 4;
   localparam int IMG_H = 4;
   localparam int S     = 1;
`endif
   localparam int K  = 3;
   localparam int RW = $clog2(IMG_H);
   localparam int CW = $clog2(IMG_W);

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             pix_valid;
   logic [PIX_W-1:0] pix_in;
   logic             pix_ready;
   logic             out_ready;
   logic             lb_en;
   logic [PIX_W-1:0] lb_pixel;
   logic             win_valid;
   logic [RW-1:0]    win_row;
   logic [CW-1:0]    win_col;
   logic             busy;
   logic             done;

   conv_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pix_valid (pix_valid),
      .pix_in    (pix_in),
      .pix_ready (pix_ready),
      .out_ready (out_ready),
      .lb_en     (lb_en),
      .lb_pixel  (lb_pixel),
      .win_valid (win_valid),
      .win_row   (win_row),
      .win_col   (win_col),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: frame progress as a pixel index, not as FSM state.
   bit m_stream = 1'b0;
   bit m_done   = 1'b0;
   int m_n      = 0;
   bit e_wv     = 1'b0;
   int e_row    = 0;
   int e_col    = 0;
   int obs_r[$];
   int obs_c[$];

   typedef struct {
      bit          r;
      bit          st;
      bit          pv;
      bit          rdy;
      logic [15:0] px;
      bit          x_rdy;
      bit          x_en;
      bit          x_busy;
      bit          x_done;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit is_window(input int r, input int c);
      return (r >= K-1) && (c >= K-1) && ((r-(K-1)) % S == 0) && ((c-(K-1)) % S == 0);
   endfunction

   // One clock: drive at edge+1, check combinational outputs, then registered ones.
   task automatic step(input bit r, input bit st, input bit pv, input bit rdy,
                       input logic [15:0] px, output bit o_rdy, output bit o_en);
      bit acc;
      int pr, pc;
      rst = r; start = st; pix_valid = pv; out_ready = rdy; pix_in = px;
      #1;
      acc   = m_stream && rdy && pv;
      o_rdy = pix_ready;
      o_en  = lb_en;
      chk("pix_ready", pix_ready, 32'(m_stream && rdy));
      chk("lb_en", lb_en, 32'(acc));
      chk("lb_pixel", lb_pixel, 32'(px));
      @(posedge clk);
      #1;
      if (!r) begin
         m_stream = 0; m_done = 0; m_n = 0; e_wv = 0; e_row = 0; e_col = 0;
      end else begin
         e_wv = 0;
         if (m_done) begin
            m_done = 0;
         end else if (!m_stream) begin
            if (st) begin
               m_stream = 1;
               m_n      = 0;
            end
         end else if (acc) begin
            pr = m_n / IMG_W;
            pc = m_n % IMG_W;
            if (is_window(pr, pc)) begin
               e_wv = 1; e_row = pr; e_col = pc;
            end
            m_n++;
            if (m_n == IMG_W * IMG_H) begin
               m_stream = 0; m_done = 1; m_n = 0;
            end
         end
      end
      chk("win_valid", win_valid, 32'(e_wv));
      chk("win_row", win_row, 32'(e_row));
      chk("win_col", win_col, 32'(e_col));
      chk("busy", busy, 32'(m_stream));
      chk("done", done, 32'(m_done));
      if (win_valid === 1'b1) begin
         obs_r.push_back(int'(win_row));
         obs_c.push_back(int'(win_col));
      end
   endtask

   task automatic compare_windows(input string nm);
      int er[$];
      int ec[$];
      for (int r = K-1; r < IMG_H; r += S)
         for (int c = K-1; c < IMG_W; c += S) begin
            er.push_back(r);
            ec.push_back(c);
         end
      chk({nm, "_count"}, obs_r.size(), ((IMG_H-K)/S+1) * ((IMG_W-K)/S+1));
      for (int i = 0; i < er.size(); i++) begin
         if (i < obs_r.size()) begin
            chk({nm, "_row"}, obs_r[i], er[i]);
            chk({nm, "_col"}, obs_c[i], ec[i]);
         end
      end
   endtask

   // mode 0: back-to-back, 1: 3-cycle out_ready stall mid-row 2, 2: bubbles
   task automatic run_frame(input int mode, input string nm);
      bit a, b;
      int cyc;
      int stall;
      bit pv, rdy;
      obs_r.delete();
      obs_c.delete();
      step(1, 1, 0, 1, 16'h0, a, b);
      cyc   = 0;
      stall = 0;
      while (!m_done && cyc < 200) begin
         pv  = 1;
         rdy = 1;
         if (mode == 1 && m_n == 2*IMG_W + 1 && stall < 3) begin
            rdy = 0;
            stall++;
         end
         if (mode == 2) pv = cyc[0];
         step(1, 0, pv, rdy, 16'(m_n * 16'h0101 + 1), a, b);
         if (mode == 1 && !rdy) chk({nm, "_stall_en"}, b, 0);
         cyc++;
      end
      if (!m_done) chk({nm, "_timeout"}, 1, 0);
      step(1, 1, 1, 1, 16'h0, a, b);
      chk({nm, "_idle_busy"}, busy, 0);
      compare_windows(nm);
   endtask

   initial begin
      bit a, b;
      int en_cnt;

      tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h3333, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h4444, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h6666, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h7777, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h8888, 1'b0, 1'b0, 1'b0, 1'b0};

      rst = 0; start = 0; pix_valid = 0; out_ready = 0; pix_in = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;

      // Reset held two more cycles, then idle without start.
      step(0, 0, 0, 0, 16'h0, a, b);
      step(0, 1, 1, 1, 16'h0, a, b);
      chk("rst_win_valid", win_valid, 0);
      chk("rst_done", done, 0);
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 1, 1, 16'hABCD, a, b);
         chk("idle_pix_ready", a, 0);
      end

      for (int i = 0; i < 8; i++) begin
         step(tbl[i].r, tbl[i].st, tbl[i].pv, tbl[i].rdy, tbl[i].px, a, b);
         chk("tbl_pix_ready", a, 32'(tbl[i].x_rdy));
         chk("tbl_lb_en", b, 32'(tbl[i].x_en));
         chk("tbl_busy", busy, 32'(tbl[i].x_busy));
         chk("tbl_done", done, 32'(tbl[i].x_done));
      end

      run_frame(0, "full");
      run_frame(1, "backpressure");
      run_frame(2, "bubbles");

      // Mid-frame reset after pixel 9, then a clean frame.
      step(1, 1, 0, 1, 16'h0, a, b);
      for (int i = 0; i < 9; i++) step(1, 0, 1, 1, 16'(i), a, b);
      step(0, 0, 1, 1, 16'h0, a, b);
      chk("midrst_busy", busy, 0);
      chk("midrst_row", win_row, 0);
      chk("midrst_col", win_col, 0);
      obs_r.delete();
      en_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 1, 1, 16'h0, a, b);
         en_cnt += int'(b);
      end
      chk("midrst_no_win", obs_r.size(), 0);
      chk("midrst_no_en", en_cnt, 0);
      run_frame(0, "after_rst");

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 79) != 0, $urandom_range(0, 5) == 0,
              1'($urandom), 1'($urandom), 16'($urandom), a, b);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
